// File: rtl/memory_port_arbiter_pkg.sv
// memory_port_arbiter_pkg: state encodings, requester IDs and arbitration modes for the memory port arbiter
package memory_port_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_e;
  typedef enum logic {REQ_I, REQ_D} req_e;
  localparam int ARB_RR = 0;
  localparam int ARB_FIXED_D = 1;
endpackage

// File: rtl/memory_port_arbiter_rr_arbiter2.sv
// rr_arbiter2: 2-way grant (round-robin or fixed d priority) with a last-grant register
module rr_arbiter2
  import memory_port_arbiter_pkg::*;
#(
  parameter int ARB_MODE = ARB_RR
) (
  input  logic clock,
  input  logic reset,
  input  logic req_i,
  input  logic req_d,
  input  logic accept,
  output logic any,
  output req_e grant
);
  req_e last;
  always_ff @(posedge clock or posedge reset)
    if (reset) last <= REQ_D;
    else if (accept) last <= grant;
  always_comb begin
    any = req_i || req_d;
    grant = !req_d ? REQ_I
          : (req_i && ARB_MODE != ARB_FIXED_D && last == REQ_D) ? REQ_I : REQ_D;
  end
endmodule

// File: rtl/memory_port_arbiter.sv
// memory_port_arbiter: shares one memory port between i and d sides, one read outstanding,
// routes the response to its owner and flags reads that never return.
module memory_port_arbiter
  import memory_port_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDRESS_BITS   = 32,
  parameter int ARB_MODE       = ARB_RR,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      i_mem_read,
  input  logic [ADDRESS_BITS-1:0]   i_mem_address_in,
  output logic                      i_mem_ready,
  output logic                      i_mem_valid,
  output logic [DATA_WIDTH-1:0]     i_mem_data_out,
  output logic [ADDRESS_BITS-1:0]   i_mem_address_out,
  input  logic                      d_mem_read,
  input  logic                      d_mem_write,
  input  logic [DATA_WIDTH/8-1:0]   d_mem_byte_en,
  input  logic [ADDRESS_BITS-1:0]   d_mem_address_in,
  input  logic [DATA_WIDTH-1:0]     d_mem_data_in,
  output logic                      d_mem_ready,
  output logic                      d_mem_valid,
  output logic [DATA_WIDTH-1:0]     d_mem_data_out,
  output logic [ADDRESS_BITS-1:0]   d_mem_address_out,
  output logic                      mem_read,
  output logic                      mem_write,
  output logic [DATA_WIDTH/8-1:0]   mem_byte_en,
  output logic [ADDRESS_BITS-1:0]   mem_address_in,
  output logic [DATA_WIDTH-1:0]     mem_data_in,
  input  logic                      mem_ready,
  input  logic                      mem_valid,
  input  logic [DATA_WIDTH-1:0]     mem_data_out,
  input  logic [ADDRESS_BITS-1:0]   mem_address_out,
  output logic                      timeout
);
  localparam int WW = $clog2(TIMEOUT_CYCLES);
  localparam logic [WW-1:0] WD_MAX = WW'(TIMEOUT_CYCLES - 1);
  state_e state, state_n;
  logic [WW-1:0] wd;
  logic any, accept, win_i, win_d, wr, resp_i, resp_d, expire;
  req_e grant;
  rr_arbiter2 #(.ARB_MODE(ARB_MODE)) arb (
    .clock(clock), .reset(reset), .req_i(i_mem_read), .req_d(d_mem_read || d_mem_write),
    .accept(accept), .any(any), .grant(grant)
  );
  // request path is gated by reset so every output reads 0 while reset is held
  always_comb begin
    win_i = state == IDLE && !reset && any && grant == REQ_I;
    win_d = state == IDLE && !reset && any && grant == REQ_D;
    wr = win_d && d_mem_write;
    mem_read = win_i || (win_d && !d_mem_write);
    mem_write = wr;
    mem_byte_en = wr ? d_mem_byte_en : '0;
    mem_data_in = wr ? d_mem_data_in : '0;
    mem_address_in = win_i ? i_mem_address_in : win_d ? d_mem_address_in : '0;
    i_mem_ready = win_i && mem_ready;
    d_mem_ready = win_d && mem_ready;
    accept = (win_i || win_d) && mem_ready;
    resp_i = state == BUSY_I && mem_valid;
    resp_d = state == BUSY_D && mem_valid;
    i_mem_valid = resp_i;
    i_mem_data_out = resp_i ? mem_data_out : '0;
    i_mem_address_out = resp_i ? mem_address_out : '0;
    d_mem_valid = resp_d;
    d_mem_data_out = resp_d ? mem_data_out : '0;
    d_mem_address_out = resp_d ? mem_address_out : '0;
    expire = state != IDLE && !mem_valid && wd == WD_MAX;
    state_n = state == IDLE ? ((accept && mem_read) ? (win_i ? BUSY_I : BUSY_D) : IDLE)
            : (mem_valid || expire) ? IDLE : state;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      wd <= '0;
      timeout <= 1'b0;
    end else begin
      state <= state_n;
      wd <= state == IDLE ? '0 : wd == WD_MAX ? wd : wd + 1'b1;
      if (expire) timeout <= 1'b1;
    end
endmodule

// File: tb/tb_memory_port_arbiter.sv
// tb_memory_port_arbiter: randomized and directed checks of two arbiter instances (round-robin/T=8,
// fixed-d/T=16) against a transaction-level reference model
module tb_memory_port_arbiter;
  localparam int DW = 32, AB = 32, BW = DW / 8;
  logic clock = 1'b0, reset = 1'b1;
  always #5 clock = ~clock;
  logic i_mem_read = 0, d_mem_read = 0, d_mem_write = 0, mem_ready = 0, mem_valid = 0;
  logic [AB-1:0] i_mem_address_in = '0, d_mem_address_in = '0, mem_address_out = '0;
  logic [DW-1:0] d_mem_data_in = '0, mem_data_out = '0;
  logic [BW-1:0] d_mem_byte_en = '0;
  typedef struct packed {
    logic i_rdy, i_vld; logic [DW-1:0] i_dat; logic [AB-1:0] i_adr;
    logic d_rdy, d_vld; logic [DW-1:0] d_dat; logic [AB-1:0] d_adr;
    logic rd, wr; logic [BW-1:0] be; logic [AB-1:0] adr; logic [DW-1:0] dat;
    logic tmo;
  } obs_t;
  obs_t obs [2];
  for (genvar g = 0; g < 2; g++) begin : inst
    obs_t o;
    memory_port_arbiter #(.DATA_WIDTH(DW), .ADDRESS_BITS(AB), .ARB_MODE(g), .TIMEOUT_CYCLES(g ? 16 : 8)) dut (
      .clock(clock), .reset(reset),
      .i_mem_read(i_mem_read), .i_mem_address_in(i_mem_address_in), .i_mem_ready(o.i_rdy),
      .i_mem_valid(o.i_vld), .i_mem_data_out(o.i_dat), .i_mem_address_out(o.i_adr),
      .d_mem_read(d_mem_read), .d_mem_write(d_mem_write), .d_mem_byte_en(d_mem_byte_en),
      .d_mem_address_in(d_mem_address_in), .d_mem_data_in(d_mem_data_in), .d_mem_ready(o.d_rdy),
      .d_mem_valid(o.d_vld), .d_mem_data_out(o.d_dat), .d_mem_address_out(o.d_adr),
      .mem_read(o.rd), .mem_write(o.wr), .mem_byte_en(o.be), .mem_address_in(o.adr),
      .mem_data_in(o.dat), .mem_ready(mem_ready), .mem_valid(mem_valid),
      .mem_data_out(mem_data_out), .mem_address_out(mem_address_out), .timeout(o.tmo)
    );
    assign obs[g] = o;
  end
  // model: owner 0=none 1=i 2=d; last 1=i 2=d; cnt = BUSY cycles already spent
  int owner [2] = '{0, 0}, last [2] = '{2, 2}, cnt [2] = '{0, 0}, tmax [2] = '{8, 16};
  bit tmo [2] = '{0, 0};
  int tests = 0, fails = 0;
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic int winner(input int k);
    logic dreq = d_mem_read || d_mem_write;
    if (reset || owner[k] != 0) return 0;
    if (i_mem_read && dreq) return (k == 1) ? 2 : (last[k] == 2 ? 1 : 2);
    return i_mem_read ? 1 : dreq ? 2 : 0;
  endfunction
  function automatic obs_t expect_out(input int k);
    obs_t e = '0;
    int w = winner(k);
    if (reset) return e;
    e.rd = w == 1 || (w == 2 && !d_mem_write);
    e.wr = w == 2 && d_mem_write;
    e.be = e.wr ? d_mem_byte_en : '0;
    e.dat = e.wr ? d_mem_data_in : '0;
    e.adr = w == 1 ? i_mem_address_in : w == 2 ? d_mem_address_in : '0;
    e.i_rdy = w == 1 && mem_ready;
    e.d_rdy = w == 2 && mem_ready;
    e.i_vld = owner[k] == 1 && mem_valid;
    e.d_vld = owner[k] == 2 && mem_valid;
    e.i_dat = e.i_vld ? mem_data_out : '0;
    e.i_adr = e.i_vld ? mem_address_out : '0;
    e.d_dat = e.d_vld ? mem_data_out : '0;
    e.d_adr = e.d_vld ? mem_address_out : '0;
    e.tmo = tmo[k];
    return e;
  endfunction
  task automatic update(input int k);
    int w = winner(k);
    if (reset) begin
      owner[k] = 0; last[k] = 2; cnt[k] = 0; tmo[k] = 0;
    end else if (owner[k] == 0) begin
      if (w != 0 && mem_ready) begin
        last[k] = w;
        if (w == 1 || !d_mem_write) begin owner[k] = w; cnt[k] = 0; end
      end
    end else if (mem_valid) owner[k] = 0;
    else if (cnt[k] == tmax[k] - 1) begin tmo[k] = 1; owner[k] = 0; end
    else cnt[k]++;
  endtask
  task automatic tick();
    #1;
    for (int k = 0; k < 2; k++) begin
      obs_t e = expect_out(k);
      obs_t o = obs[k];
      check($sformatf("m%0d_iside", k), {o.i_rdy, o.i_vld, o.i_dat, o.i_adr}, {e.i_rdy, e.i_vld, e.i_dat, e.i_adr});
      check($sformatf("m%0d_dside", k), {o.d_rdy, o.d_vld, o.d_dat, o.d_adr}, {e.d_rdy, e.d_vld, e.d_dat, e.d_adr});
      check($sformatf("m%0d_mem", k), {o.rd, o.wr, o.be, o.adr, o.dat}, {e.rd, e.wr, e.be, e.adr, e.dat});
      check($sformatf("m%0d_timeout", k), o.tmo, e.tmo);
      update(k);
    end
    @(negedge clock);
  endtask
  task automatic idle_in();
    i_mem_read = 0; d_mem_read = 0; d_mem_write = 0; mem_valid = 0; mem_ready = 1;
  endtask
  task automatic do_reset();
    reset = 1; tick(); reset = 0;
  endtask
  initial begin
    @(negedge clock);
    i_mem_read = 1; d_mem_read = 1; mem_ready = 1; mem_valid = 1;
    tick(); tick();
    reset = 0; idle_in();
    i_mem_read = 1; i_mem_address_in = 32'h100;
    tick();
    i_mem_read = 0; i_mem_address_in = '0;
    tick(); tick();
    mem_valid = 1; mem_data_out = 32'hDEADBEEF; mem_address_out = 32'h100;
    #1 check("i_resp_data", obs[0].i_dat, 32'hDEADBEEF);
    check("i_resp_valid", {obs[0].i_vld, obs[0].d_vld}, 2'b10);
    tick();
    do_reset(); idle_in();
    i_mem_read = 1; d_mem_read = 1; mem_valid = 1;
    i_mem_address_in = 32'h40; d_mem_address_in = 32'h80;
    for (int n = 0; n < 8; n++) tick();
    idle_in();
    d_mem_write = 1; d_mem_address_in = 32'h200; d_mem_byte_en = 4'b0011; d_mem_data_in = 32'h1234;
    tick();
    d_mem_write = 0; i_mem_read = 1; i_mem_address_in = 32'h300;
    #1 check("i_after_write", obs[0].i_rdy, 1'b1);
    tick();
    idle_in(); mem_valid = 1; tick();
    idle_in(); mem_ready = 0; i_mem_read = 1; d_mem_read = 1;
    for (int n = 0; n < 3; n++) tick();
    mem_ready = 1; tick();
    idle_in(); mem_valid = 1; tick();
    do_reset(); idle_in();
    i_mem_read = 1; tick(); i_mem_read = 0;
    for (int n = 0; n < 7; n++) tick();
    #1 check("timeout_early", obs[0].tmo, 1'b0);
    tick();
    check("timeout_set", obs[0].tmo, 1'b1);
    for (int n = 0; n < 10; n++) tick();
    do_reset(); idle_in();
    d_mem_read = 1; tick(); d_mem_read = 0; tick();
    reset = 1; tick(); reset = 0;
    mem_valid = 1; mem_data_out = 32'hCAFEF00D; tick();
    for (int n = 0; n < 4000; n++) begin
      reset = $urandom_range(0, 199) == 0;
      i_mem_read = $urandom_range(0, 2) != 0;
      d_mem_read = $urandom_range(0, 1);
      d_mem_write = $urandom_range(0, 3) == 0;
      mem_ready = $urandom_range(0, 3) != 0;
      mem_valid = $urandom_range(0, 4) == 0;
      i_mem_address_in = $urandom; d_mem_address_in = $urandom;
      d_mem_data_in = $urandom; d_mem_byte_en = BW'($urandom);
      mem_data_out = $urandom; mem_address_out = $urandom;
      tick();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
